// File: rtl/nbr_pkg.sv
// Shared constants and helpers for the neighbour operand-fetch stage.
// Maps top-of-register-space addresses onto mesh neighbour channels.
package nbr_pkg;

    typedef enum logic [2:0] {
        NORTH = 3'd0,
        SOUTH = 3'd1,
        WEST  = 3'd2,
        EAST  = 3'd3
    } dir_e;

    localparam int REG_TOP = 31;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;
    localparam int RS3_LSB = 27;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } dir_hit_t;

    // Address REG_TOP-d names channel d when d is a real channel.
    function automatic dir_hit_t dir_of(input logic [4:0] addr,
                                        input int num_dir);
        dir_hit_t   r;
        logic [4:0] off;
        off   = 5'(REG_TOP) - addr;
        r.idx = off[2:0];
        r.hit = (32'(off) < num_dir);
        return r;
    endfunction

endpackage

// File: rtl/nbr_operand_fetch_if.sv
// Bus bundle between decode/regfile/neighbours and the operand-fetch stage.
// The stage sits on the slave side; the environment drives the master side.
interface nbr_operand_fetch_if #(
    parameter int XLEN    = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_DIR = 4
);
    logic                     inst_valid;
    logic [31:0]              inst;
    logic                     is_psrf_sw;
    logic                     inst_ready;
    logic [NUM_RD*5-1:0]      ra;
    logic [NUM_RD*XLEN-1:0]   rf_rdata;
    logic [NUM_DIR-1:0]       nbr_valid;
    logic [NUM_DIR*XLEN-1:0]  nbr_data;
    logic [NUM_DIR-1:0]       nbr_ready;
    logic                     op_valid;
    logic [NUM_RD*XLEN-1:0]   op_data;
    logic [NUM_RD*5-1:0]      op_ra;
    logic                     op_ready;

    modport master (
        output inst_valid, inst, is_psrf_sw, rf_rdata,
        output nbr_valid, nbr_data, op_ready,
        input  inst_ready, ra, nbr_ready, op_valid, op_data, op_ra
    );

    modport slave (
        input  inst_valid, inst, is_psrf_sw, rf_rdata,
        input  nbr_valid, nbr_data, op_ready,
        output inst_ready, ra, nbr_ready, op_valid, op_data, op_ra
    );

endinterface

// File: rtl/nbr_fifo.sv
// Single-clock elastic FIFO for one neighbour channel.
// No fall-through: a pushed word becomes visible on the following cycle.
module nbr_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_pop,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_full,
    output logic            o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("nbr_fifo: DEPTH must be a power of two >= 2");
    end

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic            r_full;
    logic [AW-1:0]   w_wp_nxt;

    assign w_wp_nxt = r_wp + AW'(1);
    assign o_full   = r_full;
    assign o_empty  = (r_wp == r_rp) && !r_full;
    assign o_rdata  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_wdata;
    end

    // Equal pointers are ambiguous; r_full records which case it is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_full <= 1'b0;
        end else begin
            if (i_push) r_wp <= w_wp_nxt;
            if (i_pop)  r_rp <= r_rp + AW'(1);
            if (i_push && !i_pop && w_wp_nxt == r_rp)
                r_full <= 1'b1;
            else if (i_pop && !i_push)
                r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/nbr_operand_fetch.sv
// Operand-fetch stage for a mesh PE: register file or neighbour channels.
// Stalls until all named neighbour operands are present, then pops them.
module nbr_operand_fetch
    import nbr_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_DIR    = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nbr_operand_fetch_if.slave   bus,
    output logic [CNT_W-1:0]     stall_cnt
);

    if ((NUM_RD != 2 && NUM_RD != 3) || NUM_DIR < 1 || NUM_DIR > 8)
    begin : g_bad_cfg
        $error("nbr_operand_fetch: illegal NUM_RD/NUM_DIR");
    end

    logic [4:0]          w_addr [NUM_RD];
    dir_hit_t            w_dh   [NUM_RD];
    logic [XLEN-1:0]     w_opnd [NUM_RD];
    logic [XLEN-1:0]     w_head [NUM_DIR];
    logic [NUM_DIR-1:0]  w_need;
    logic [NUM_DIR-1:0]  w_full;
    logic [NUM_DIR-1:0]  w_empty;
    logic [NUM_DIR-1:0]  w_push;
    logic [NUM_DIR-1:0]  w_pop;
    logic [NUM_RD*5-1:0] w_ra;
    logic [NUM_RD*XLEN-1:0] w_opnd_flat;
    logic                w_slot_free;
    logic                w_blocked;
    logic                w_fire;
    logic                w_unused;

    logic                   r_op_valid;
    logic [NUM_RD*XLEN-1:0] r_op_data;
    logic [NUM_RD*5-1:0]    r_op_ra;
    logic [CNT_W-1:0]       r_stall;

    assign w_unused = ^bus.inst;

    always_comb begin
        w_addr[0] = bus.inst[RS1_LSB +: 5];
        w_addr[1] = bus.is_psrf_sw ? bus.inst[RD_LSB +: 5]
                                   : bus.inst[RS2_LSB +: 5];
        if (NUM_RD == 3) w_addr[NUM_RD-1] = bus.inst[RS3_LSB +: 5];
    end

    always_comb begin
        w_need      = '0;
        w_ra        = '0;
        w_opnd_flat = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_dh[p]   = dir_of(w_addr[p], NUM_DIR);
            w_opnd[p] = bus.rf_rdata[p*XLEN +: XLEN];
            for (int d = 0; d < NUM_DIR; d++) begin
                if (w_dh[p].hit && w_dh[p].idx == 3'(d)) begin
                    w_opnd[p] = w_head[d];
                    if (bus.inst_valid) w_need[d] = 1'b1;
                end
            end
            w_ra[p*5 +: 5]           = w_addr[p];
            w_opnd_flat[p*XLEN +: XLEN] = w_opnd[p];
        end
    end

    assign w_slot_free = !r_op_valid || bus.op_ready;
    assign w_blocked   = |(w_need & w_empty);
    assign w_fire      = bus.inst_valid && w_slot_free && !w_blocked;
    assign w_pop       = w_need & {NUM_DIR{w_fire}};
    assign w_push      = bus.nbr_valid & bus.nbr_ready;

    assign bus.nbr_ready  = ~w_full & {NUM_DIR{!rst}};
    assign bus.inst_ready = w_fire;
    assign bus.ra         = w_ra;
    assign bus.op_valid   = r_op_valid;
    assign bus.op_data    = r_op_data;
    assign bus.op_ra      = r_op_ra;
    assign stall_cnt      = r_stall;

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_ch
        nbr_fifo #(
            .XLEN  (XLEN),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[d]),
            .i_wdata (bus.nbr_data[d*XLEN +: XLEN]),
            .i_pop   (w_pop[d]),
            .o_rdata (w_head[d]),
            .o_full  (w_full[d]),
            .o_empty (w_empty[d])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_valid <= 1'b0;
            r_op_data  <= '0;
            r_op_ra    <= '0;
        end else if (w_fire) begin
            r_op_valid <= 1'b1;
            r_op_data  <= w_opnd_flat;
            r_op_ra    <= w_ra;
        end else if (bus.op_ready) begin
            r_op_valid <= 1'b0;
        end
    end

    // Only neighbour starvation counts; backpressure is execute's problem.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall <= '0;
        else if (bus.inst_valid && w_slot_free && !w_fire && r_stall != '1)
            r_stall <= r_stall + CNT_W'(1);
    end

endmodule

// File: tb/tb_nbr_operand_fetch.sv
// Directed bench for nbr_operand_fetch: register, neighbour, backpressure,
// full-FIFO and reset scenarios with hand-computed expectations.
module tb_nbr_operand_fetch;

    localparam int XLEN  = 32;
    localparam int NRD   = 2;
    localparam int NDIR  = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] stall_cnt;
    int               passed;
    int               failed;
    int               total;

    nbr_operand_fetch_if #(
        .XLEN    (XLEN),
        .NUM_RD  (NRD),
        .NUM_DIR (NDIR)
    ) bus ();

    nbr_operand_fetch #(
        .XLEN       (XLEN),
        .NUM_RD     (NRD),
        .NUM_DIR    (NDIR),
        .FIFO_DEPTH (2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] rs3,
                                       input logic [4:0] rs2,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rd);
        return {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] data);
        bus.nbr_valid[d]              = 1'b1;
        bus.nbr_data[d*XLEN +: XLEN]  = data;
        tick();
        bus.nbr_valid[d]              = 1'b0;
    endtask

    // Combinational look at inst_ready without letting an edge see it.
    task automatic probe(input string tag, input logic [31:0] ins,
                         input logic exp);
        bus.inst       = ins;
        bus.inst_valid = 1'b1;
        #1;
        chk(tag, 64'(bus.inst_ready), 64'(exp));
        bus.inst_valid = 1'b0;
    endtask

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        rst            = 1'b1;
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        bus.is_psrf_sw = 1'b0;
        bus.rf_rdata   = '0;
        bus.nbr_valid  = '0;
        bus.nbr_data   = '0;
        bus.op_ready   = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_nbr_ready", 64'(bus.nbr_ready), 64'h0);
        chk("rst_op_valid", 64'(bus.op_valid), 64'h0);
        chk("rst_op_data", 64'(bus.op_data), 64'h0);
        chk("rst_stall", 64'(stall_cnt), 64'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.nbr_ready), 64'hf);

        // 1: register-only operands
        bus.rf_rdata   = {32'h6, 32'h5};
        bus.inst       = mk(5'd0, 5'd6, 5'd5, 5'd0);
        bus.inst_valid = 1'b1;
        #1;
        chk("t1_ra", 64'(bus.ra), 64'({5'd6, 5'd5}));
        chk("t1_inst_ready", 64'(bus.inst_ready), 64'h1);
        tick();
        bus.inst_valid = 1'b0;
        chk("t1_op_valid", 64'(bus.op_valid), 64'h1);
        chk("t1_op_data", 64'(bus.op_data), {32'h6, 32'h5});
        chk("t1_op_ra", 64'(bus.op_ra), 64'({5'd6, 5'd5}));
        chk("t1_stall", 64'(stall_cnt), 64'h0);
        tick();
        chk("t1_drain", 64'(bus.op_valid), 64'h0);

        // 2: stall on empty north
        bus.inst       = mk(5'd0, 5'd5, 5'd31, 5'd0);
        bus.inst_valid = 1'b1;
        #1;
        chk("t2_blocked", 64'(bus.inst_ready), 64'h0);
        tick();
        tick();
        tick();
        chk("t2_stall3", 64'(stall_cnt), 64'd3);
        bus.nbr_valid[0]     = 1'b1;
        bus.nbr_data[31:0]   = 32'hDEADBEEF;
        #1;
        chk("t2_no_fallthru", 64'(bus.inst_ready), 64'h0);
        tick();
        bus.nbr_valid[0] = 1'b0;
        #1;
        chk("t2_stall4", 64'(stall_cnt), 64'd4);
        chk("t2_ready_now", 64'(bus.inst_ready), 64'h1);
        tick();
        bus.inst_valid = 1'b0;
        chk("t2_op_data", 64'(bus.op_data), {32'h6, 32'hDEADBEEF});
        chk("t2_stall_held", 64'(stall_cnt), 64'd4);
        probe("t2_north_empty", mk(5'd0, 5'd5, 5'd31, 5'd0), 1'b0);

        // 3: same channel on both ports
        push(1, 32'h11);
        push(1, 32'h22);
        #1;
        chk("t3_south_full", 64'(bus.nbr_ready), 64'b1101);
        bus.inst       = mk(5'd0, 5'd30, 5'd30, 5'd0);
        bus.inst_valid = 1'b1;
        #1;
        chk("t3_fire", 64'(bus.inst_ready), 64'h1);
        tick();
        bus.inst_valid = 1'b0;
        chk("t3_op_data", 64'(bus.op_data), {32'h11, 32'h11});
        chk("t3_one_pop", 64'(bus.nbr_ready), 64'hf);
        bus.inst       = mk(5'd0, 5'd5, 5'd30, 5'd0);
        bus.inst_valid = 1'b1;
        tick();
        bus.inst_valid = 1'b0;
        chk("t3_second", 64'(bus.op_data), {32'h6, 32'h22});
        probe("t3_south_empty", mk(5'd0, 5'd5, 5'd30, 5'd0), 1'b0);

        // 4: psrf_sw addressing through port 1
        push(3, 32'h77);
        bus.is_psrf_sw = 1'b1;
        bus.inst       = mk(5'd0, 5'd3, 5'd5, 5'd28);
        bus.inst_valid = 1'b1;
        #1;
        chk("t4_ra", 64'(bus.ra), 64'({5'd28, 5'd5}));
        tick();
        bus.inst_valid = 1'b0;
        bus.is_psrf_sw = 1'b0;
        chk("t4_op_data", 64'(bus.op_data), {32'h77, 32'h5});
        chk("t4_op_ra", 64'(bus.op_ra), 64'({5'd28, 5'd5}));

        // 5: backpressure and a full west FIFO
        bus.rf_rdata   = {32'hA, 32'hB};
        bus.inst       = mk(5'd0, 5'd6, 5'd5, 5'd0);
        bus.inst_valid = 1'b1;
        tick();
        bus.op_ready   = 1'b0;
        bus.inst       = mk(5'd0, 5'd6, 5'd29, 5'd0);
        bus.rf_rdata   = {32'hC, 32'hD};
        push(2, 32'h101);
        push(2, 32'h202);
        #1;
        chk("t5_west_full", 64'(bus.nbr_ready), 64'b1011);
        push(2, 32'h303);
        chk("t5_hold_valid", 64'(bus.op_valid), 64'h1);
        chk("t5_hold_data", 64'(bus.op_data), {32'hA, 32'hB});
        chk("t5_hold_ra", 64'(bus.op_ra), 64'({5'd6, 5'd5}));
        chk("t5_no_stall", 64'(stall_cnt), 64'd4);
        chk("t5_bp_blocked", 64'(bus.inst_ready), 64'h0);
        bus.op_ready = 1'b1;
        #1;
        chk("t5_release", 64'(bus.inst_ready), 64'h1);
        tick();
        chk("t5_w1", 64'(bus.op_data), {32'hC, 32'h101});
        tick();
        bus.inst_valid = 1'b0;
        chk("t5_w2", 64'(bus.op_data), {32'hC, 32'h202});
        chk("t5_stall_held", 64'(stall_cnt), 64'd4);
        probe("t5_w3_dropped", mk(5'd0, 5'd6, 5'd29, 5'd0), 1'b0);

        // 6: reset mid-operation
        bus.op_ready   = 1'b0;
        bus.inst       = mk(5'd0, 5'd6, 5'd5, 5'd0);
        bus.inst_valid = 1'b1;
        tick();
        bus.inst_valid = 1'b0;
        push(3, 32'h99);
        chk("t6_pending", 64'(bus.op_valid), 64'h1);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 64'(bus.nbr_ready), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_op_valid", 64'(bus.op_valid), 64'h0);
        chk("t6_stall", 64'(stall_cnt), 64'h0);
        chk("t6_op_data", 64'(bus.op_data), 64'h0);
        chk("t6_ready_after", 64'(bus.nbr_ready), 64'hf);
        bus.op_ready = 1'b1;
        probe("t6_east_empty", mk(5'd0, 5'd6, 5'd28, 5'd0), 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
